// File: rtl/fork8_pkg.sv
// Shared types and default sizing for the 8-way fork sequencer.
package fork8_pkg;
  localparam int FORK8_NUM_OUT   = 8;
  localparam int FORK8_TIMEOUT_W = 16;
  localparam int FORK8_CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE,
    ST_ERR
  } state_t;
endpackage

// File: rtl/fork8_watchdog.sv
// Saturating wait timer; expire fires on the cycle the timer reaches limit-1.
module fork8_watchdog
  import fork8_pkg::*;
#(
  parameter int TIMEOUT_W = FORK8_TIMEOUT_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 en,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expire
);
  logic [TIMEOUT_W-1:0] timer_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer_reg <= '0;
    end else if (clr) begin
      timer_reg <= '0;
    end else if (en && (timer_reg != '1)) begin
      timer_reg <= timer_reg + TIMEOUT_W'(1);
    end
  end

  // A zero limit disables the watchdog entirely.
  assign expire = en && (limit != '0) && (timer_reg == (limit - TIMEOUT_W'(1)));
endmodule

// File: rtl/fork8_sync_ctrl.sv
// Fork sequencer: one upstream token fans out as drive pulses to masked
// branches, and free is returned upstream once every enabled branch has freed.
module fork8_sync_ctrl
  import fork8_pkg::*;
#(
  parameter int NUM_OUT   = FORK8_NUM_OUT,
  parameter int TIMEOUT_W = FORK8_TIMEOUT_W,
  parameter int CNT_W     = FORK8_CNT_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_drive,
  output logic                 o_free,
  input  logic [NUM_OUT-1:0]   i_cfg_mask,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  output logic [NUM_OUT-1:0]   o_driveNext_8,
  input  logic [NUM_OUT-1:0]   i_freeNext_8,
  input  logic                 i_err_clr,
  output logic                 o_busy,
  output logic [NUM_OUT-1:0]   o_pending,
  output logic                 o_err_timeout,
  output logic                 o_err_proto,
  output logic [CNT_W-1:0]     o_tok_cnt
);
  state_t               state_reg, state_next;
  logic [NUM_OUT-1:0]   pending_reg, pending_next;
  logic [NUM_OUT-1:0]   drive_reg, drive_next;
  logic [NUM_OUT-1:0]   remaining;
  logic                 free_reg, free_next;
  logic                 busy_reg;
  logic                 err_tmo_reg, err_tmo_next;
  logic                 err_proto_reg, err_proto_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 wd_clr, wd_en, wd_expire;

  fork8_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (wd_clr),
    .en     (wd_en),
    .limit  (i_timeout),
    .expire (wd_expire)
  );

  always_comb begin
    state_next     = state_reg;
    pending_next   = pending_reg;
    drive_next     = '0;
    free_next      = 1'b0;
    cnt_next       = cnt_reg;
    err_tmo_next   = err_tmo_reg;
    err_proto_next = err_proto_reg;
    wd_clr         = 1'b0;
    wd_en          = 1'b0;
    // Frees on bits that are not pending simply have no effect here.
    remaining      = pending_reg & ~i_freeNext_8;

    case (state_reg)
      ST_IDLE: begin
        if (i_err_clr) err_proto_next = 1'b0;
        if (i_drive) begin
          if (i_cfg_mask == '0) begin
            state_next = ST_RELEASE;
            free_next  = 1'b1;
          end else begin
            state_next   = ST_ISSUE;
            pending_next = i_cfg_mask;
            drive_next   = i_cfg_mask;
          end
        end
      end
      ST_ISSUE: begin
        wd_clr       = 1'b1;
        pending_next = remaining;
        if (remaining == '0) begin
          state_next = ST_RELEASE;
          free_next  = 1'b1;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wd_en        = 1'b1;
        pending_next = remaining;
        // Completion is tested first so a last free on the expiry cycle wins.
        if (remaining == '0) begin
          state_next = ST_RELEASE;
          free_next  = 1'b1;
        end else if (wd_expire) begin
          state_next   = ST_ERR;
          err_tmo_next = 1'b1;
        end
      end
      ST_RELEASE: begin
        cnt_next   = cnt_reg + CNT_W'(1);
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        pending_next = remaining;
        if (i_err_clr) begin
          pending_next   = '0;
          err_tmo_next   = 1'b0;
          err_proto_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (i_drive && (state_reg != ST_IDLE) && !((state_reg == ST_ERR) && i_err_clr))
      err_proto_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      pending_reg   <= '0;
      drive_reg     <= '0;
      free_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      err_tmo_reg   <= 1'b0;
      err_proto_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      drive_reg     <= drive_next;
      free_reg      <= free_next;
      busy_reg      <= (state_next != ST_IDLE);
      err_tmo_reg   <= err_tmo_next;
      err_proto_reg <= err_proto_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign o_free        = free_reg;
  assign o_driveNext_8 = drive_reg;
  assign o_busy        = busy_reg;
  assign o_pending     = pending_reg;
  assign o_err_timeout = err_tmo_reg;
  assign o_err_proto   = err_proto_reg;
  assign o_tok_cnt     = cnt_reg;
endmodule

// File: tb/tb_fork8_sync_ctrl.sv
// Randomized token-level bench: each token's timing is predicted from its mask,
// per-branch free latencies and watchdog limit, then compared cycle by cycle.
module tb_fork8_sync_ctrl;
  localparam int NB = 8;
  localparam int TW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_drive;
  logic          o_free;
  logic [NB-1:0] i_cfg_mask;
  logic [TW-1:0] i_timeout;
  logic [NB-1:0] o_driveNext_8;
  logic [NB-1:0] i_freeNext_8;
  logic          i_err_clr;
  logic          o_busy;
  logic [NB-1:0] o_pending;
  logic          o_err_timeout;
  logic          o_err_proto;
  logic [CW-1:0] o_tok_cnt;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            lat_arr[NB];
  logic [CW-1:0] tok_model = '0;

  fork8_sync_ctrl #(.NUM_OUT(NB), .TIMEOUT_W(TW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_drive       (i_drive),
    .o_free        (o_free),
    .i_cfg_mask    (i_cfg_mask),
    .i_timeout     (i_timeout),
    .o_driveNext_8 (o_driveNext_8),
    .i_freeNext_8  (i_freeNext_8),
    .i_err_clr     (i_err_clr),
    .o_busy        (o_busy),
    .o_pending     (o_pending),
    .o_err_timeout (o_err_timeout),
    .o_err_proto   (o_err_proto),
    .o_tok_cnt     (o_tok_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    i_drive      = 1'b0;
    i_cfg_mask   = '0;
    i_freeNext_8 = '0;
    i_err_clr    = 1'b0;
  endtask

  // Branch b frees in cycle 1+lat_arr[b] (cycle 1 is the drive cycle).
  task automatic run_token(input logic [NB-1:0] mask, input int tmo, input bit stray, input bit proto);
    int maxlat, c_done, e_cyc, last, p_cyc;
    bit to_err;
    logic [NB-1:0] fr, exp_pend;
    logic [CW-1:0] tok_after;
    maxlat = 0;
    for (int b = 0; b < NB; b++)
      if (mask[b] && lat_arr[b] > maxlat) maxlat = lat_arr[b];
    c_done = (mask == '0) ? 0 : 1 + maxlat;
    to_err = (mask != '0) && (tmo != 0) && (c_done > tmo + 1);
    e_cyc  = tmo + 2;
    last   = to_err ? e_cyc + 1 : c_done + 2;
    p_cyc  = (proto && !to_err && c_done >= 2) ? int'($urandom_range(2, c_done)) : -1;
    tok_after = to_err ? tok_model : tok_model + CW'(1);

    for (int n = 0; n <= last; n++) begin
      i_drive    = (n == 0) || (n == p_cyc);
      i_cfg_mask = (n == 0) ? mask : NB'($urandom);
      i_timeout  = TW'(tmo);
      i_err_clr  = to_err && (n == e_cyc);
      fr = '0;
      for (int b = 0; b < NB; b++)
        if (mask[b] && n >= 1 && (1 + lat_arr[b] == n) && !(to_err && n >= e_cyc)) fr[b] = 1'b1;
      if (stray) fr = fr | (NB'($urandom) & ~mask);
      i_freeNext_8 = fr;

      @(negedge clk);
      exp_pend = '0;
      if (n >= 1 && (to_err ? (n <= e_cyc) : (n <= c_done)))
        for (int b = 0; b < NB; b++)
          if (mask[b] && (1 + lat_arr[b] >= n)) exp_pend[b] = 1'b1;
      check("drive",   32'(o_driveNext_8), 32'((n == 1) ? mask : '0));
      check("free",    32'(o_free),        32'(!to_err && n == c_done + 1));
      check("pending", 32'(o_pending),     32'(exp_pend));
      check("busy",    32'(o_busy),        32'(to_err ? (n >= 1 && n <= e_cyc) : (n >= 1 && n <= c_done + 1)));
      check("err_tmo", 32'(o_err_timeout), 32'(to_err && n == e_cyc));
      check("err_pro", 32'(o_err_proto),   32'(p_cyc > 0 && n > p_cyc));
      if (n == 0)    check("cnt_pre", 32'(o_tok_cnt), 32'(tok_model));
      if (n == last) check("cnt",     32'(o_tok_cnt), 32'(tok_after));
      @(posedge clk);
      #1;
    end
    idle_inputs();
    tok_model = tok_after;
    if (p_cyc > 0) begin
      i_err_clr = 1'b1;
      @(posedge clk);
      #1;
      i_err_clr = 1'b0;
      check("proto_clr", 32'(o_err_proto), 32'(0));
      check("proto_idle", 32'(o_busy), 32'(0));
    end
    $display("token mask=%h tmo=%0d done=%0d err=%0b proto=%0d cnt=%0d",
             mask, tmo, c_done, to_err, p_cyc, o_tok_cnt);
  endtask

  initial begin
    rstn = 1'b0;
    i_timeout = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_free", 32'(o_free), 32'(0));
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_cnt",  32'(o_tok_cnt), 32'(0));
    check("rst_pend", 32'(o_pending), 32'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Full mask, frees on bits 0..7 in cycles 3..10.
    for (int b = 0; b < NB; b++) lat_arr[b] = b + 2;
    run_token(8'hFF, 0, 1'b0, 1'b0);
    // Partial mask with stray frees on unmasked bits, frees in cycle 4.
    for (int b = 0; b < NB; b++) lat_arr[b] = 3;
    run_token(8'h05, 0, 1'b1, 1'b0);
    // Zero-latency consumers and zero mask.
    for (int b = 0; b < NB; b++) lat_arr[b] = 0;
    run_token(8'h0F, 0, 1'b0, 1'b0);
    run_token(8'h00, 0, 1'b0, 1'b0);
    // Watchdog expiry, then the last free landing exactly on the expiry cycle.
    lat_arr[0] = 1;
    lat_arr[1] = 1000;
    run_token(8'h03, 4, 1'b0, 1'b0);
    lat_arr[1] = 4;
    run_token(8'h03, 4, 1'b0, 1'b0);
    // Protocol violation while waiting.
    for (int b = 0; b < NB; b++) lat_arr[b] = 6;
    run_token(8'h81, 0, 1'b0, 1'b1);

    for (int t = 0; t < 60; t++) begin
      logic [NB-1:0] m;
      int tmo;
      m   = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom);
      tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(3, 15));
      for (int b = 0; b < NB; b++) lat_arr[b] = int'($urandom_range(0, 12));
      run_token(m, tmo, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // Enough zero-mask tokens to wrap the counter.
    for (int t = 0; t < 220; t++) run_token(8'h00, 0, 1'b0, 1'b0);

    // Reset while waiting on branches 4 and 5 abandons the token.
    for (int b = 0; b < NB; b++) lat_arr[b] = 1000;
    i_drive = 1'b1;
    i_cfg_mask = 8'h30;
    i_timeout = '0;
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("mid_pend", 32'(o_pending), 32'(8'h30));
    #2 rstn = 1'b0;
    #1;
    check("async_busy", 32'(o_busy), 32'(0));
    check("async_pend", 32'(o_pending), 32'(0));
    check("async_free", 32'(o_free), 32'(0));
    check("async_cnt",  32'(o_tok_cnt), 32'(0));
    @(posedge clk);
    #1;
    check("rst_hold_free", 32'(o_free), 32'(0));
    rstn = 1'b1;
    tok_model = '0;
    for (int b = 0; b < NB; b++) lat_arr[b] = 2;
    run_token(8'h5A, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
